// File: rtl/fifo_sync_delay.sv
// Synchronous FIFO with occupancy/threshold flags, sticky error flags and a delay-line mode.
// Latency: a write is readable the next cycle; data_o/data_vld are registered one cycle after the read is accepted.
// Backpressure: writes to a full FIFO are rejected (ovf) unless a read is accepted in the same cycle; reads of an empty FIFO are rejected (udf).
module fifo_sync_delay #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AF_LVL = DEPTH - 2,
  parameter int AE_LVL = 2,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              mode,
  input  logic [AW-1:0]     delay_cfg,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] data_i,
  input  logic              rd_en,
  input  logic              err_clr,
  output logic [DATA_W-1:0] data_o,
  output logic              data_vld,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [AW:0]       count,
  output logic              ovf,
  output logic              udf
);

  // Thresholds sized to the count register so all flag compares are width-matched.
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_C    = (AW+1)'(AF_LVL);
  localparam logic [AW:0] AE_C    = (AW+1)'(AE_LVL);

  // Storage is intentionally not reset; pointers and count define validity.
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic [DATA_W-1:0] data_o_q, data_o_d;
  logic              data_vld_q, data_vld_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;

  logic              full_w;
  logic              empty_w;
  logic [AW-1:0]     delay_eff;
  logic [AW:0]       delay_ext;
  logic              rd_req;
  logic              rd_acc;
  logic              wr_acc;
  logic              ovf_set;
  logic              udf_set;

  // Flags decode from the registered count only, so they describe the state after the last edge.
  always_comb begin
    full_w  = (count_q == DEPTH_C);
    empty_w = (count_q == '0);
  end

  // Read/write acceptance; in delay-line mode reads are generated to hold occupancy at the delay.
  always_comb begin
    delay_eff = (delay_cfg == '0) ? AW'(1) : delay_cfg;
    delay_ext = {1'b0, delay_eff};
    if (mode) begin
      // A write arriving exactly at the delay releases the oldest sample in the same cycle.
      rd_req = (count_q > delay_ext) || (wr_en && (count_q == delay_ext));
    end else begin
      rd_req = rd_en;
    end
    rd_acc  = en && rd_req && !empty_w;
    // A full FIFO still accepts a write when a read frees a slot in the same cycle.
    wr_acc  = en && wr_en && (!full_w || rd_acc);
    ovf_set = en && wr_en && !wr_acc;
    udf_set = en && !mode && rd_en && !rd_acc;
  end

  // Next-state for pointers, count, read data and error flags.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_o_d   = data_o_q;
    data_vld_d = data_vld_q;
    ovf_d      = ovf_q;
    udf_d      = udf_q;

    if (en) begin
      data_vld_d = rd_acc;
      if (rd_acc) begin
        data_o_d = mem_q[rd_ptr_q];
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      unique case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end

    // Clear is honoured even while disabled; a new error in the same cycle wins.
    if (err_clr) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (ovf_set) ovf_d = 1'b1;
    if (udf_set) udf_d = 1'b1;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_o_q   <= '0;
      data_vld_q <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_o_q   <= data_o_d;
      data_vld_q <= data_vld_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  // Storage write; suppressed during reset so reset fully overrides wr_en.
  always_ff @(posedge clk) begin
    if (rst_n && wr_acc) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Output drive.
  always_comb begin
    data_o       = data_o_q;
    data_vld     = data_vld_q;
    full         = full_w;
    empty        = empty_w;
    almost_full  = (count_q >= AF_C);
    almost_empty = (count_q <= AE_C);
    count        = count_q;
    ovf          = ovf_q;
    udf          = udf_q;
  end

endmodule
